// File: rtl/div_pkg.sv
// Shared types and helpers for the 8-bit sequential divider: FSM states,
// datapath width, step count and two's-complement magnitude helpers.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic [DIV_WIDTH-1:0] neg8(input logic [DIV_WIDTH-1:0] v);
    return ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // -128 maps to 8'h80, which is still the correct unsigned magnitude (128).
  function automatic logic [DIV_WIDTH-1:0] mag8(input logic [DIV_WIDTH-1:0] v,
                                                input logic is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? neg8(v) : v;
  endfunction

endpackage

// File: rtl/div_step_8bits.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor magnitude if it fits.
module div_step_8bits
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_in,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 bit_in,
  output logic [DIV_WIDTH-1:0] rem_out,
  output logic                 q_out
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] diff;

  // rem_in < div_in keeps shifted < 2*div_in, so diff's top bit is a clean borrow.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, div_in};
    q_out   = ~diff[DIV_WIDTH];
    rem_out = q_out ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  end

endmodule

// File: rtl/div_8bits_seq.sv
// Sequential 8-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips CALC and finishes at once.
module div_8bits_seq
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] A,
  input  logic [DIV_WIDTH-1:0] B,
  input  logic                 Signed,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] Quot,
  output logic [DIV_WIDTH-1:0] Rem,
  output logic                 DivZero
);

  // Handshake: start is accepted on a rising edge only while busy is low;
  // done pulses for one cycle and Quot/Rem/DivZero stay valid until the next
  // operation completes.

  localparam logic [2:0] STEP_LAST = 3'(DIV_STEPS - 1);

  div_state_t           state;
  div_state_t           state_next;
  logic [2:0]           cnt;
  logic [DIV_WIDTH-1:0] a_sh;
  logic [DIV_WIDTH-1:0] a_cap;
  logic [DIV_WIDTH-1:0] b_mag;
  logic [DIV_WIDTH-1:0] rem_acc;
  logic [DIV_WIDTH-1:0] quo_acc;
  logic                 neg_q;
  logic                 neg_r;
  logic                 dz_q;
  logic [DIV_WIDTH-1:0] step_rem;
  logic                 step_q;

  div_step_8bits u_step (
    .rem_in  (rem_acc),
    .div_in  (b_mag),
    .bit_in  (a_sh[DIV_WIDTH-1]),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          state_next = (B == '0) ? DONE : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == STEP_LAST) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      a_sh    <= '0;
      a_cap   <= '0;
      b_mag   <= '0;
      rem_acc <= '0;
      quo_acc <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_q    <= 1'b0;
      done    <= 1'b0;
      Quot    <= '0;
      Rem     <= '0;
      DivZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= mag8(A, Signed);
            b_mag   <= mag8(B, Signed);
            a_cap   <= A;
            rem_acc <= '0;
            quo_acc <= '0;
            cnt     <= '0;
            neg_q   <= Signed & (A[DIV_WIDTH-1] ^ B[DIV_WIDTH-1]);
            neg_r   <= Signed & A[DIV_WIDTH-1];
            dz_q    <= (B == '0);
          end
        end
        CALC: begin
          rem_acc <= step_rem;
          quo_acc <= {quo_acc[DIV_WIDTH-2:0], step_q};
          a_sh    <= {a_sh[DIV_WIDTH-2:0], 1'b0};
          cnt     <= cnt + 3'd1;
        end
        DONE: begin
          done <= 1'b1;
          if (dz_q) begin
            Quot    <= '1;
            Rem     <= a_cap;
            DivZero <= 1'b1;
          end else begin
            // Sign fix-up; -128/-1 wraps naturally to 8'h80.
            Quot    <= neg_q ? neg8(quo_acc) : quo_acc;
            Rem     <= neg_r ? neg8(rem_acc) : rem_acc;
            DivZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_8bits_seq.sv
// Self-checking bench for div_8bits_seq: directed corner cases plus random
// operands scored against an integer-arithmetic reference model.
module tb_div_8bits_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Signed;
  logic       busy;
  logic       done;
  logic [7:0] Quot;
  logic [7:0] Rem;
  logic       DivZero;

  int n_checks;
  int n_fail;

  logic [16:0] exp_q[$];

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  div_8bits_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
    .Signed  (Signed),
    .busy    (busy),
    .done    (done),
    .Quot    (Quot),
    .Rem     (Rem),
    .DivZero (DivZero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: {DivZero, Quot, Rem}
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ai;
    int bi;
    int qi;
    int ri;
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    if (s) begin
      ai = int'($signed(a));
      bi = int'($signed(b));
    end else begin
      ai = int'(a);
      bi = int'(b);
    end
    qi = ai / bi;
    ri = ai % bi;
    return {1'b0, qi[7:0], ri[7:0]};
  endfunction

  function automatic int exp_lat(input logic [7:0] b);
    return (FAST && b == 8'd0) ? 1 : 9;
  endfunction

  // Called at #1 after the accepting edge; waits for done and scores it.
  task automatic wait_done(input int lat, input int inj);
    int n;
    int busy_cnt;
    logic [16:0] e;
    n = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && n < 30) begin
      if (n == inj) begin
        A = 8'($urandom_range(0, 255));
        B = 8'($urandom_range(1, 255));
        Signed = 1'($urandom_range(0, 1));
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done !== 1'b1 && busy === 1'b1) busy_cnt++;
    end
    check("latency", n, lat);
    check("busy_cycles", busy_cnt, lat);
    check("busy_at_done", {31'd0, busy}, 0);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("quot", {24'd0, Quot}, {24'd0, e[15:8]});
      check("rem", {24'd0, Rem}, {24'd0, e[7:0]});
      check("divzero", {31'd0, DivZero}, {31'd0, e[16]});
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input int inj);
    exp_q.push_back(model(a, b, s));
    @(negedge clk);
    A = a;
    B = b;
    Signed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(exp_lat(b), inj);
  endtask

  // No further done pulses and results held steady.
  task automatic idle_check(input int ncyc, input logic [16:0] e);
    int cnt;
    cnt = 0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) cnt++;
    end
    check("no_extra_done", cnt, 0);
    check("hold_quot", {24'd0, Quot}, {24'd0, e[15:8]});
    check("hold_rem", {24'd0, Rem}, {24'd0, e[7:0]});
    check("hold_divzero", {31'd0, DivZero}, {31'd0, e[16]});
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    A = 8'd0;
    B = 8'd0;
    Signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_quot", {24'd0, Quot}, 0);
    check("rst_rem", {24'd0, Rem}, 0);
    check("rst_divzero", {31'd0, DivZero}, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed values
    run_op(8'd15, 8'd5, 1'b0, -1);
    check("dir_15_5_q", {24'd0, Quot}, 32'h03);
    idle_check(3, model(8'd15, 8'd5, 1'b0));
    run_op(8'hEF, 8'd5, 1'b1, -1);
    check("dir_m17_5_q", {24'd0, Quot}, 32'hFD);
    check("dir_m17_5_r", {24'd0, Rem}, 32'hFE);
    run_op(8'd17, 8'hFB, 1'b1, -1);
    check("dir_17_m5_r", {24'd0, Rem}, 32'h02);
    run_op(8'hF1, 8'hFB, 1'b1, -1);
    run_op(8'h80, 8'hFF, 1'b1, -1);
    check("dir_m128_m1_q", {24'd0, Quot}, 32'h80);
    run_op(8'hFF, 8'h01, 1'b0, -1);
    run_op(8'd3, 8'd0, 1'b0, -1);
    check("dir_div0_rem", {24'd0, Rem}, 32'h03);
    idle_check(2, model(8'd3, 8'd0, 1'b0));
    run_op(8'h85, 8'd0, 1'b1, -1);

    // start ignored while busy
    run_op(8'd15, 8'd5, 1'b0, 4);
    idle_check(15, model(8'd15, 8'd5, 1'b0));

    // back-to-back: start held in the done cycle is taken on the next edge
    run_op(8'd200, 8'd7, 1'b0, -1);
    exp_q.push_back(model(8'd100, 8'd9, 1'b0));
    A = 8'd100;
    B = 8'd9;
    Signed = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 1);
    check("b2b_done_pulse", {31'd0, done}, 0);
    wait_done(9, -1);

    // reset mid-CALC discards the operation
    @(negedge clk);
    A = 8'd50;
    B = 8'd3;
    Signed = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    check("mid_rst_quot", {24'd0, Quot}, 0);
    check("mid_rst_rem", {24'd0, Rem}, 0);
    check("mid_rst_divzero", {31'd0, DivZero}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(12, 17'd0);
    run_op(8'd50, 8'd3, 1'b0, -1);

    // reset wins over start on the same edge
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    A = 8'd9;
    B = 8'd2;
    @(posedge clk);
    #1;
    check("rst_vs_start_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;

    // random stimulus
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, -1);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_8bits_seq.md
DIV_8BITS_SEQ -- requirements
Module: div_8bits_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-004 SHALL have port A, input, 8, dividend; captured on the accepting edge.
REQ-005 SHALL have port B, input, 8, divisor; captured on the accepting edge.
REQ-006 SHALL have port Signed, input, 1, 1 = two's-complement operands, 0 = unsigned; captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1, high in CALC and DONE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse; results valid.
REQ-009 SHALL have port Quot, output, 8, quotient.
REQ-010 SHALL have port Rem, output, 8, remainder.
REQ-011 SHALL have port DivZero, output, 1, high when the captured B was zero; held with the results.

Function
REQ-012 SHALL implement FSM IDLE -> CALC (start=1) -> DONE (after 8 CALC cycles) -> IDLE (unconditional, 1 cycle).
REQ-013 SHALL perform restoring division on operand magnitudes, one quotient bit per CALC cycle, MSB first, using a 3-bit step counter 0..7.
REQ-014 SHALL assert done exactly on the 9th rising edge after the edge that accepted start; busy high for those 9 cycles.
REQ-015 SHALL ignore start while busy=1; the operation in flight is unaffected.
REQ-016 SHALL accept start in the cycle done is high only on the following edge (DONE returns to IDLE first); back-to-back throughput is one result per 10 cycles.
REQ-017 SHALL hold Quot, Rem and DivZero stable from done until the next accepting edge.
REQ-018 Signed mode: quotient truncates toward zero; Quot negative iff operand signs differ; Rem carries the dividend's sign; A = Quot*B + Rem holds in 8-bit arithmetic.
REQ-019 SHALL return Quot=8'h80, Rem=8'h00 for signed -128 / -1 (wrap, no flag).
REQ-020 SHALL return Quot=8'hFF, Rem=A, DivZero=1 when B=0, in either mode.
REQ-021 Unsigned mode: Quot=A/B, Rem=A%B, full 0..255 range.

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE and clear busy, done, Quot, Rem, DivZero and the step counter to 0, including mid-operation; the in-flight result is discarded.
REQ-023 rst SHALL take priority over start on the same edge.

Configuration
REQ-024 Macro DIV_ZERO_FAST_EN defined: B=0 SHALL skip CALC and go IDLE -> DONE, so done asserts on the 1st edge after acceptance, with REQ-020 values.
REQ-025 Macro DIV_ZERO_FAST_EN undefined: divide-by-zero SHALL take the full REQ-014 latency.

Structure
REQ-026 Package div_pkg SHALL hold the FSM state enum typedef (IDLE, CALC, DONE), DIV_WIDTH=8 and DIV_STEPS=8.
REQ-027 The single shift-subtract step SHALL be a combinational sub-module div_step_8bits (partial remainder, divisor magnitude, next dividend bit in; next partial remainder, quotient bit out).

Verification
REQ-028 Unsigned A=15, B=5 -> done on 9th edge, Quot=8'h03, Rem=8'h00, DivZero=0.
REQ-029 Signed A=-17, B=5 -> Quot=8'hFD, Rem=8'hFE; signed A=17, B=-5 -> Quot=8'hFD, Rem=8'h02; signed A=-15, B=-5 -> Quot=8'h03, Rem=8'h00.
REQ-030 Signed A=-128, B=-1 -> Quot=8'h80, Rem=8'h00; unsigned A=255, B=1 -> Quot=8'hFF, Rem=8'h00.
REQ-031 A=3, B=0 -> Quot=8'hFF, Rem=8'h03, DivZero=1; done on the 9th edge without DIV_ZERO_FAST_EN, on the 1st edge with it.
REQ-032 start pulsed with new operands at cycle 4 of a busy operation -> ignored; first result unchanged; no second done.
REQ-033 rst at cycle 5 of CALC -> next cycle busy=0, done=0, outputs 0; a fresh start then completes normally.
